// File: rtl/sblk_pkg.sv
// sblk_pkg: shared geometry of one SuperBlock unit's activation path.
// The {bank, row} address field puts the bank bit in the MSB.
package sblk_pkg;
   localparam int N_TILE      = 40;
   localparam int WID_ACT     = 16;
   localparam int WID_ACTADDR = 6;
   localparam int ROWS        = 2 ** (WID_ACTADDR - 2);
   localparam int WID_ROW     = $clog2(ROWS);
   localparam int WID_TILE    = $clog2(N_TILE);
   localparam int WID_HBIT    = WID_ACTADDR - 1;
   localparam int HBIT_BANK   = WID_HBIT - 1;
   function automatic logic [WID_HBIT-1:0] mk_hbit(input logic bank, input logic [WID_ROW-1:0] row);
      logic [WID_HBIT-1:0] h;
      h = '0;
      h[HBIT_BANK] = bank;
      h[WID_ROW-1:0] = row;
      return h;
   endfunction
endpackage

// File: rtl/sblk_tile_row_cnt.sv
// sblk_tile_row_cnt: nested tile (inner) / row (outer) beat counter for one bank.
// Flags the last beat of the bank using the row limit latched on its first beat.
module sblk_tile_row_cnt
   import sblk_pkg::*;
(
   input  logic                clk_l,
   input  logic                rst_n,
   input  logic                inc,
   input  logic [WID_ROW-1:0]  rows_m1,
   output logic [WID_TILE-1:0] tile,
   output logic [WID_ROW-1:0]  row,
   output logic                last
);
   logic [WID_TILE-1:0] r_tile;
   logic [WID_ROW-1:0]  r_row;
   logic [WID_ROW-1:0]  r_rows_m1;
   logic                w_first;
   logic                w_tile_end;
   logic [WID_ROW-1:0]  w_lim;
   assign w_first    = (r_tile == '0) && (r_row == '0);
   // the limit loads on the first beat's own edge, so that beat compares against the live config
   assign w_lim      = w_first ? rows_m1 : r_rows_m1;
   assign w_tile_end = r_tile == WID_TILE'(N_TILE - 1);
   assign last       = w_tile_end && (r_row == w_lim);
   assign tile       = r_tile;
   assign row        = r_row;
   always_ff @(posedge clk_l) begin
      if (!rst_n) begin
         r_tile    <= '0;
         r_row     <= '0;
         r_rows_m1 <= '0;
      end else if (inc) begin
         if (w_first) r_rows_m1 <= rows_m1;
         r_tile <= w_tile_end ? '0 : r_tile + 1'b1;
         r_row  <= last ? '0 : (w_tile_end ? r_row + 1'b1 : r_row);
      end
   end
endmodule

// File: rtl/sblk_act_loader.sv
// sblk_act_loader: scatters a stream of activation pairs over the SuperTiles of one unit,
// double-banked with full flags owned by compute until released.
module sblk_act_loader
   import sblk_pkg::*;
(
   input  logic                   clk_l,
   input  logic                   rst_n,
   input  logic [2*WID_ACT-1:0]   s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [WID_ROW-1:0]     cfg_rows_m1,
   input  logic                   bank_release,
   output logic [2*WID_ACT-1:0]   act_data_in,
   output logic [N_TILE-1:0]      act_wr_en,
   output logic [WID_HBIT-1:0]    act_wr_addr_hbit,
   output logic [1:0]             bank_full,
   output logic                   rd_bank,
   output logic                   err_release
);
   logic [1:0]           r_full;
   logic                 r_wr_bank;
   logic                 r_rd_bank;
   logic                 r_err;
   logic [2*WID_ACT-1:0] r_data;
   logic                 r_v1;
   logic [WID_TILE-1:0]  r_tile1;
   logic [WID_HBIT-1:0]  r_hbit1;
   logic [WID_HBIT-1:0]  r_hbit2;
   logic [N_TILE-1:0]    r_en;
   logic                 w_acc;
   logic                 w_last;
   logic                 w_rel_ok;
   logic [WID_TILE-1:0]  w_tile;
   logic [WID_ROW-1:0]   w_row;
   logic [1:0]           w_full_nx;
   assign s_ready  = rst_n && !r_full[r_wr_bank];
   assign w_acc    = s_valid && s_ready;
   assign w_rel_ok = bank_release && r_full[r_rd_bank];
   sblk_tile_row_cnt u_cnt (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .inc     (w_acc),
      .rows_m1 (cfg_rows_m1),
      .tile    (w_tile),
      .row     (w_row),
      .last    (w_last)
   );
   // a completing fill and a release can never hit the same bank, so both updates apply
   always_comb begin
      w_full_nx = r_full;
      if (w_acc && w_last) w_full_nx[r_wr_bank] = 1'b1;
      if (w_rel_ok) w_full_nx[r_rd_bank] = 1'b0;
   end
   always_ff @(posedge clk_l) begin
      if (!rst_n) begin
         r_full    <= '0;
         r_wr_bank <= 1'b0;
         r_rd_bank <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_full    <= w_full_nx;
         r_wr_bank <= r_wr_bank ^ (w_acc && w_last);
         r_rd_bank <= r_rd_bank ^ w_rel_ok;
         r_err     <= r_err | (bank_release && !r_full[r_rd_bank]);
      end
   end
   // strobe and address trail the data by one stage to meet the unit's internal data register
   always_ff @(posedge clk_l) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_v1    <= 1'b0;
         r_tile1 <= '0;
         r_hbit1 <= '0;
         r_hbit2 <= '0;
         r_en    <= '0;
      end else begin
         r_data  <= w_acc ? s_data : r_data;
         r_v1    <= w_acc;
         r_tile1 <= w_tile;
         r_hbit1 <= mk_hbit(r_wr_bank, w_row);
         r_hbit2 <= r_hbit1;
         r_en    <= r_v1 ? N_TILE'(1) << r_tile1 : '0;
      end
   end
   assign act_data_in      = r_data;
   assign act_wr_en        = r_en;
   assign act_wr_addr_hbit = r_hbit2;
   assign bank_full        = r_full;
   assign rd_bank          = r_rd_bank;
   assign err_release      = r_err;
endmodule

// File: tb/tb_sblk_act_loader.sv
// tb_sblk_act_loader: directed table, hand-written corner sequences and random traffic,
// all checked every cycle against a beat-count reference model of the loader.
module tb_sblk_act_loader;
   import sblk_pkg::*;
   logic                 clk_l;
   logic                 rst_n;
   logic [2*WID_ACT-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [WID_ROW-1:0]   cfg_rows_m1;
   logic                 bank_release;
   logic [2*WID_ACT-1:0] act_data_in;
   logic [N_TILE-1:0]    act_wr_en;
   logic [WID_HBIT-1:0]  act_wr_addr_hbit;
   logic [1:0]           bank_full;
   logic                 rd_bank;
   logic                 err_release;

   sblk_act_loader dut (
      .clk_l            (clk_l),
      .rst_n            (rst_n),
      .s_data           (s_data),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .cfg_rows_m1      (cfg_rows_m1),
      .bank_release     (bank_release),
      .act_data_in      (act_data_in),
      .act_wr_en        (act_wr_en),
      .act_wr_addr_hbit (act_wr_addr_hbit),
      .bank_full        (bank_full),
      .rd_bank          (rd_bank),
      .err_release      (err_release)
   );

   initial clk_l = 1'b0;
   always #5 clk_l = ~clk_l;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: a bank is just a count of beats; tile/row come from div/mod
   int                   m_cnt, m_rows;
   logic                 m_wr, m_rd, m_err;
   logic [1:0]           m_full;
   logic [N_TILE-1:0]    m_en;
   logic [WID_HBIT-1:0]  m_hbit, p1_hbit;
   logic [2*WID_ACT-1:0] m_data;
   bit                   m_dv, m_hv, p1_v, m_init;
   int                   p1_tile;

   logic                 sn_ready, sn_rd, sn_err;
   logic [1:0]           sn_full;
   logic [N_TILE-1:0]    sn_en;
   logic [WID_HBIT-1:0]  sn_hbit;
   logic [2*WID_ACT-1:0] sn_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic [31:0] d, input logic rel, input logic [3:0] cfg);
      logic exp_rdy, acc, last, rel_ok;
      int   tile, row;
      @(negedge clk_l);
      rst_n = rst; s_valid = v; s_data = d; bank_release = rel; cfg_rows_m1 = cfg;
      #1;
      sn_ready = s_ready; sn_en = act_wr_en; sn_full = bank_full; sn_rd = rd_bank;
      sn_err = err_release; sn_hbit = act_wr_addr_hbit; sn_data = act_data_in;
      exp_rdy = rst && !m_full[m_wr];
      if (m_init) begin
         chk("s_ready", sn_ready, exp_rdy);
         chk("act_wr_en", sn_en, m_en);
         chk("bank_full", sn_full, m_full);
         chk("rd_bank", sn_rd, m_rd);
         chk("err_release", sn_err, m_err);
         if (m_dv) chk("act_data_in", sn_data, m_data);
         if (m_hv || m_en != '0) chk("act_wr_addr_hbit", sn_hbit, m_hbit);
      end
      if (!rst) begin
         m_cnt = 0; m_rows = 0; m_wr = 0; m_rd = 0; m_err = 0; m_full = 0;
         m_en = '0; m_hbit = '0; m_data = '0; m_dv = 1; m_hv = 1;
         p1_v = 0; p1_tile = 0; p1_hbit = '0; m_init = 1;
      end else begin
         acc = v && exp_rdy;
         last = 0;
         m_en = p1_v ? (N_TILE'(1) << p1_tile) : '0;
         m_hbit = p1_hbit;
         m_hv = 0;
         m_dv = acc;
         p1_v = acc;
         if (acc) begin
            if (m_cnt == 0) m_rows = int'(cfg);
            tile = m_cnt % N_TILE;
            row = m_cnt / N_TILE;
            last = (m_cnt + 1 == N_TILE * (m_rows + 1));
            p1_tile = tile;
            p1_hbit = {m_wr, 4'(row)};
            m_cnt = last ? 0 : m_cnt + 1;
            m_data = d;
         end
         rel_ok = rel && m_full[m_rd];
         if (rel && !m_full[m_rd]) m_err = 1;
         if (acc && last) begin
            m_full[m_wr] = 1;
            m_wr = !m_wr;
         end
         if (rel_ok) begin
            m_full[m_rd] = 0;
            m_rd = !m_rd;
         end
      end
   endtask

   task automatic beats(input int n, input int base, input logic [3:0] cfg);
      for (int k = 0; k < n; k++) step(1, 1, 32'(base + k), 0, cfg);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1, 0, 32'h0, 0, 4'd1);
   endtask

   typedef struct {
      logic              rst, v, rel;
      logic              rdy;
      logic [1:0]        full;
      logic              rd, err;
      logic [N_TILE-1:0] en;
   } vec_t;
   vec_t tbl[8];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 0; s_valid = 0; s_data = '0; bank_release = 0; cfg_rows_m1 = '0;
      m_init = 0;
      // directed: reset state, spurious release (sticky), first beat after it, reset clearing err
      tbl[0] = '{1, 0, 0, 1, 2'b00, 0, 0, '0};
      tbl[1] = '{1, 0, 1, 1, 2'b00, 0, 0, '0};
      tbl[2] = '{1, 0, 0, 1, 2'b00, 0, 1, '0};
      tbl[3] = '{1, 1, 0, 1, 2'b00, 0, 1, '0};
      tbl[4] = '{1, 0, 0, 1, 2'b00, 0, 1, '0};
      tbl[5] = '{1, 0, 0, 1, 2'b00, 0, 1, 40'h1};
      tbl[6] = '{0, 0, 0, 0, 2'b00, 0, 1, '0};
      tbl[7] = '{1, 0, 0, 1, 2'b00, 0, 0, '0};
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].rst, tbl[i].v, 32'h55, tbl[i].rel, 4'd1);
         chk("tbl_ready", sn_ready, tbl[i].rdy);
         chk("tbl_full", sn_full, tbl[i].full);
         chk("tbl_rd", sn_rd, tbl[i].rd);
         chk("tbl_err", sn_err, tbl[i].err);
         chk("tbl_en", sn_en, tbl[i].en);
      end

      // single bank: 80 beats, rows_m1=1
      step(0, 0, 0, 0, 1);
      beats(80, 0, 4'd1);
      step(1, 0, 0, 0, 1);
      chk("single_full", sn_full, 2'b01);
      step(1, 0, 0, 0, 1);
      chk("single_last_en", sn_en, N_TILE'(1) << (N_TILE - 1));
      chk("single_last_hbit", sn_hbit, {1'b0, 4'd1});

      // back-pressure: fill bank 1 too, then release bank 0
      beats(80, 80, 4'd1);
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 32'hdead, 0, 1);
         chk("bp_ready_low", sn_ready, 1'b0);
      end
      step(1, 1, 32'hdead, 1, 1);
      step(1, 1, 32'h1234, 0, 1);
      chk("bp_rd_bank", sn_rd, 1'b1);
      chk("bp_full", sn_full, 2'b10);
      chk("bp_ready_high", sn_ready, 1'b1);
      idle(2);
      chk("bp_en", sn_en, 40'h1);
      chk("bp_bank_msb", sn_hbit[HBIT_BANK], 1'b0);

      // simultaneous last beat of bank 1 and release of bank 0
      step(0, 0, 0, 0, 1);
      beats(80, 0, 4'd1);
      beats(79, 100, 4'd1);
      step(1, 1, 32'h777, 1, 1);
      step(1, 1, 32'h888, 0, 1);
      chk("sim_full", sn_full, 2'b10);
      chk("sim_rd", sn_rd, 1'b1);
      idle(2);
      chk("sim_wr_bank_msb", sn_hbit[HBIT_BANK], 1'b0);
      chk("sim_wr_en", sn_en, 40'h1);

      // reset mid-fill
      step(0, 0, 0, 0, 1);
      beats(25, 500, 4'd3);
      step(0, 1, 32'h99, 0, 1);
      chk("rst_ready_low", sn_ready, 1'b0);
      step(1, 1, 32'habc, 0, 1);
      chk("rst_data_zero", sn_data, '0);
      chk("rst_en_zero", sn_en, '0);
      chk("rst_hbit_zero", sn_hbit, '0);
      idle(2);
      chk("rst_first_en", sn_en, 40'h1);
      chk("rst_first_hbit", sn_hbit, '0);

      // alignment: valid every other cycle
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 24; i++) step(1, (i % 2) == 0, 32'(i + 7), 0, 1);
      idle(3);

      // random traffic with occasional resets
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 999) != 0, $urandom_range(0, 9) < 7, $urandom,
              $urandom_range(0, 19) == 0, 4'($urandom_range(0, 3)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sblk_act_loader.md
# sblk_act_loader

Upstream feeder for one SuperBlock unit. Accepts a valid/ready stream of activation pairs (two WID_ACT words per beat) and scatters them across the activation buffers of the N_TILE SuperTiles. It drives the unit's `act_data_in`, `act_wr_en` and `act_wr_addr_hbit` inputs. Activation storage is double-banked: the loader fills one bank while the compute side reads the other, and bank ownership is exchanged through full flags and a release pulse.

## Interface
- N_TILE, 40, SuperTiles per unit; width of the write-enable vector.
- WID_ACT, 16, activation word width; one beat carries two words.
- WID_ACTADDR, 6, activation buffer address width. `act_wr_addr_hbit` is WID_ACTADDR-1 bits, formed as {bank, row}.
- ROWS, 2**(WID_ACTADDR-2), maximum rows per tile per bank.

Ports:
- clk_l  in  1  clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- s_data  in  2*WID_ACT  activation pair for the current beat.
- s_valid  in  1  beat valid.
- s_ready  out  1  beat accepted when s_valid && s_ready.
- cfg_rows_m1  in  WID_ACTADDR-2  rows per tile minus one; sampled on the first beat of each bank.
- bank_release  in  1  one-cycle pulse from compute: finished with bank `rd_bank`.
- act_data_in  out  2*WID_ACT  data to the SuperBlock unit.
- act_wr_en  out  N_TILE  one-hot or zero tile write strobe.
- act_wr_addr_hbit  out  WID_ACTADDR-1  {bank, row}.
- bank_full  out  2  per-bank "loaded, owned by compute" flags.
- rd_bank  out  1  bank compute must read next.
- err_release  out  1  sticky flag; set by a release while bank_full[rd_bank]==0.

## Operation
- **Beat ordering:** beat k of a bank goes to tile = k mod N_TILE and row = k / N_TILE. The tile counter is inner; the row counter is outer.
- **Bank size:** a bank holds N_TILE*(cfg_rows_m1+1) beats. `cfg_rows_m1` is latched when tile==0 and row==0 and a beat is accepted. Changing it mid-bank has no effect.
- **Ready:** `s_ready = rst_n && !bank_full[wr_bank]`, where wr_bank is an internal pointer. Otherwise s_ready is combinational on registered state only; it never depends on s_valid.
- **Accept, not last beat:** increment tile; on tile==N_TILE-1, wrap tile to 0 and increment row.
- **Accept, last beat** (tile==N_TILE-1 and row==latched rows_m1):
  - set bank_full[wr_bank];
  - toggle wr_bank;
  - clear tile and row.
- **Release:** `bank_release` with bank_full[rd_bank]==1 clears that flag and toggles rd_bank. With bank_full[rd_bank]==0 it changes no state except setting err_release.
- **Simultaneous events:** a last-beat set and a release in the same cycle always target different banks, and both take effect.
  - If both banks are full, s_ready=0.
  - A release then reopens the released bank. s_ready rises the next cycle.
- **Reset:**
  - all counters, wr_bank, rd_bank, bank_full and err_release go to 0;
  - act_wr_en, act_data_in and act_wr_addr_hbit go to 0;
  - s_ready is 0 while rst_n==0;
  - reset mid-bank discards the partial fill.
- **Arithmetic:** counters are unsigned with no saturation; wrap occurs only at the stated bounds. The row counter is WID_ACTADDR-2 bits and the tile counter is $clog2(N_TILE) bits.

## Timing
- Accept at cycle t. `act_data_in` carries the beat at t+1, from one register stage.
- `act_wr_en` (bit = tile) and `act_wr_addr_hbit` are valid at t+2, from two register stages. This offsets the unit's internal one-cycle data register, so data, enable and address coincide at the tile buffer.
- act_wr_en is all-zero in any cycle with no accepted beat two cycles earlier.
- Full back-to-back throughput: one beat per cycle while s_ready stays high.
- `bank_full` and `rd_bank` update at t+1 relative to the last-beat accept or the release. `bank_full` therefore rises one cycle before the last write strobe reaches the tile. Compute must wait at least 2 cycles after `bank_full` rises before reading.
- err_release is set at t+1 and is cleared only by reset.

## Structure
- Shared package `sblk_pkg`: N_TILE, WID_ACT, WID_ACTADDR and ROWS defaults, plus the hbit field layout (bank bit is the MSB).
- One natural sub-module, `sblk_tile_row_cnt`: the tile/row nested counter with a last-beat output. Ports: clk_l, rst_n, inc, rows_m1, tile, row, last.
- Bank flags, pointers and the output pipeline stay in the top level.

## Test plan
- **Single bank:** N_TILE=40, cfg_rows_m1=1, 80 continuous beats with s_data=k.
  - act_wr_en sweeps tiles 0..39 with row 0, then 0..39 with row 1; hbit MSB=0.
  - bank_full=2'b01 one cycle after the 80th accept.
  - Beat k's data at the tile equals k.
- **Back-pressure:** fill both banks with no release.
  - s_ready=0 after beat 160.
  - Pulse bank_release: rd_bank=1, bank_full=2'b10, s_ready=1 the next cycle.
  - The next beat writes bank 0, hbit MSB=0.
- **Simultaneous events:** bank 0 full, and the last beat of bank 1 is accepted in the same cycle as bank_release.
  - Next cycle: bank_full=2'b10, rd_bank=1, wr_bank=0.
- **Spurious release:** bank_release with bank_full=0 → err_release=1 and sticky; counters and pointers are unchanged.
- **Reset mid-fill:** after 25 beats, assert rst_n=0 for one cycle.
  - All outputs are 0 and s_ready=0 during reset.
  - The next beat lands at tile 0, row 0, bank 0.
- **Alignment:** s_valid toggling every other cycle.
  - The act_data_in→act_wr_en offset stays exactly one cycle.
  - act_wr_en is zero in the gap cycles.
